if_prefetch_unit: RTL and testbench

- Parametrised instruction-fetch stage for the pipelined RV32I core. It replaces the free-running PC/IR register pair with three mechanisms:
  - a request/response instruction-memory handshake that tolerates wait states;
  - an in-order prefetch queue;
  - redirect/flush handling that discards stale in-flight responses.
- It sits between instruction memory and the decode stage. It supplies the instruction word and PC to decode and accepts branch/jump redirects from execute/memory.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/if_prefetch_unit.sv | 130 +++++++++++++
 tb/tb_if_prefetch_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the RV32I pipeline.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    // Base opcodes (insn[6:0])
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // One fetched instruction as held in the prefetch queue.
    typedef struct packed {
        logic [31:0]     insn;
        logic [XLEN-1:0] pc;
        logic            fault;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with synchronous clear; pointers carry an extra wrap bit so
// full and empty are distinguishable. Storage is not reset.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    // A push at full succeeds when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer next-state; clear wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage write.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: credit-limited request issue, in-order prefetch queue,
// and redirect handling that drops responses for requests issued before a redirect.
// The queue entry layout follows cpu_pkg::XLEN; override both together.
module if_prefetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned     XLEN     = cpu_pkg::XLEN,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            im_req_valid,
    input  logic            im_req_ready,
    output logic [XLEN-1:0] im_req_addr,
    input  logic            im_rsp_valid,
    input  logic [31:0]     im_rsp_data,
    input  logic            im_rsp_err,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_ir,
    output logic [XLEN-1:0] id_pc,
    output logic            id_fault,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CntW-1:0] fifo_count;
    logic            fifo_empty;
    logic            fifo_full_unused;
    logic            credit_ok;
    logic            req_fire;
    logic            rsp_drop;
    logic            fifo_push;
    logic            fifo_pop;
    logic [XLEN-1:0] redirect_target;
    logic            unused_redirect_lsb;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    assign redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Every issued request is guaranteed a queue slot, so responses are never stalled.
    assign credit_ok    = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < (CntW+1)'(DEPTH);
    assign im_req_valid = !rst && !redirect_valid && credit_ok;
    assign im_req_addr  = pc_q;
    assign req_fire     = im_req_valid && im_req_ready;

    assign rsp_drop   = im_rsp_valid && (drop_cnt_q != '0);
    assign fifo_push  = im_rsp_valid && !rsp_drop && !redirect_valid;
    assign fifo_pop   = !fifo_empty && id_ready && !redirect_valid;
    assign push_entry = '{insn: im_rsp_data, pc: rsp_pc_q, fault: im_rsp_err};

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .clear (redirect_valid),
        .push  (fifo_push),
        .wdata (push_entry),
        .pop   (fifo_pop),
        .rdata (head_entry),
        .full  (fifo_full_unused),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Decode-side view of the queue head; NOP and the next expected PC when empty.
    always_comb begin
        id_valid = !fifo_empty;
        id_ir    = NOP_INSN;
        id_pc    = rsp_pc_q;
        id_fault = 1'b0;
        if (!fifo_empty) begin
            id_ir    = head_entry.insn;
            id_pc    = head_entry.pc;
            id_fault = head_entry.fault;
        end
    end

    // Next-state for fetch PC, response PC, in-flight count and drop count.
    always_comb begin
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;

        unique case ({req_fire, im_rsp_valid})
            2'b10:   outstanding_d = outstanding_q + CntW'(1);
            2'b01:   outstanding_d = outstanding_q - CntW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            pc_d       = redirect_target;
            rsp_pc_d   = redirect_target;
            drop_cnt_d = outstanding_d;
        end else begin
            if (req_fire)  pc_d       = pc_q + XLEN'(4);
            if (fifo_push) rsp_pc_d   = rsp_pc_q + XLEN'(4);
            if (rsp_drop)  drop_cnt_d = drop_cnt_q - CntW'(1);
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench for if_prefetch_unit: in-order memory model with configurable latency,
// expected-instruction queue filled by the stimulus, negedge monitor that checks it.
module tb_if_prefetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        im_req_valid;
    logic        im_req_ready;
    logic [31:0] im_req_addr;
    logic        im_rsp_valid = 1'b0;
    logic [31:0] im_rsp_data  = '0;
    logic        im_rsp_err   = 1'b0;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_ir;
    logic [31:0] id_pc;
    logic        id_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_errors = 0;

    if_prefetch_unit #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .im_req_valid   (im_req_valid),
        .im_req_ready   (im_req_ready),
        .im_req_addr    (im_req_addr),
        .im_rsp_valid   (im_rsp_valid),
        .im_rsp_data    (im_rsp_data),
        .im_rsp_err     (im_rsp_err),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_ir          (id_ir),
        .id_pc          (id_pc),
        .id_fault       (id_fault),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'h5A5A_0013;
    endfunction

    // Memory model: requests answered in order, lat cycles after acceptance.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       pend[$];
    int          lat      = 1;
    logic        err_en   = 1'b0;
    logic [31:0] err_addr = '0;
    int          cyc      = 0;
    int          req_cnt  = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            pend.delete();
        end else if (im_req_valid && im_req_ready) begin
            pend.push_back('{addr: im_req_addr, due: cyc + lat - 1});
            req_cnt = req_cnt + 1;
        end
        #1;
        if (!rst && pend.size() != 0 && pend[0].due <= cyc) begin
            im_rsp_valid = 1'b1;
            im_rsp_data  = mem_word(pend[0].addr);
            im_rsp_err   = err_en && (pend[0].addr == err_addr);
            void'(pend.pop_front());
        end else begin
            im_rsp_valid = 1'b0;
            im_rsp_data  = '0;
            im_rsp_err   = 1'b0;
        end
    end

    // Scoreboard of instructions decode is expected to consume, in order.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic        fault;
    } exp_t;

    exp_t sb[$];

    task automatic push_exp(input logic [31:0] pc, input logic f);
        sb.push_back('{pc: pc, ir: mem_word(pc), fault: f});
    endtask

    // Monitor: every decode handshake is compared with the scoreboard head.
    always @(negedge clk) begin
        if (!rst && id_valid && id_ready) begin
            n_checks = n_checks + 1;
            if (sb.size() == 0) begin
                n_errors = n_errors + 1;
                $display("FAIL unexpected_delivery: got pc=%h ir=%h, required no delivery",
                         id_pc, id_ir);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (id_pc !== e.pc || id_ir !== e.ir || id_fault !== e.fault) begin
                    n_errors = n_errors + 1;
                    $display("FAIL delivery: got pc=%h ir=%h fault=%b, required pc=%h ir=%h fault=%b",
                             id_pc, id_ir, id_fault, e.pc, e.ir, e.fault);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Hold reset over two edges, release mid-cycle just after a rising edge.
    task automatic start(input int lat_v, input logic rdy);
        rst            = 1'b1;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        lat            = lat_v;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        id_ready = rdy;
    endtask

    // Wait until the scoreboard is drained, then stall decode.
    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_checks = n_checks + 1;
        if (sb.size() != 0) begin
            n_errors = n_errors + 1;
            $display("FAIL %s_drain: got %0d entries outstanding after %0d cycles, required 0",
                     name, sb.size(), budget);
            sb.delete();
        end
        id_ready = 1'b0;
    endtask

    initial begin
        int c2;
        int rc0;
        rst            = 1'b1;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        im_req_ready   = 1'b1;
        #1;
        chk("rst_req_valid", {31'b0, im_req_valid}, 32'd0);
        chk("rst_id_valid",  {31'b0, id_valid},     32'd0);
        chk("rst_id_ir",     id_ir,                 NOP);
        chk("rst_id_pc",     id_pc,                 32'h0);
        chk("rst_id_fault",  {31'b0, id_fault},     32'd0);

        // Zero-wait memory: 2-cycle start-up, then one instruction per cycle.
        for (int i = 0; i < 8; i++) push_exp(32'(i * 4), 1'b0);
        start(1, 1'b1);
        @(negedge clk);
        chk("t1_startup0_valid", {31'b0, id_valid}, 32'd0);
        chk("t1_startup0_ir",    id_ir,             NOP);
        @(negedge clk);
        chk("t1_startup1_valid", {31'b0, id_valid}, 32'd0);
        @(negedge clk);
        chk("t1_first_valid",    {31'b0, id_valid}, 32'd1);
        c2 = cyc;
        wait_drain("t1", 50);
        chk("t1_rate", 32'(cyc - c2), 32'd8);

        // Decode stalled: fetch stops after DEPTH requests, then resumes in order.
        rc0 = req_cnt;
        start(1, 1'b0);
        repeat (10) @(negedge clk);
        chk("t2_req_valid_low", {31'b0, im_req_valid}, 32'd0);
        chk("t2_req_count",     32'(req_cnt - rc0),    32'd4);
        chk("t2_head_pc",       id_pc,                 32'h0);
        for (int i = 0; i < 6; i++) push_exp(32'(i * 4), 1'b0);
        @(posedge clk);
        #1;
        id_ready = 1'b1;
        wait_drain("t2", 50);

        // 3-cycle memory, redirect with two requests in flight.
        push_exp(32'h100, 1'b0);
        push_exp(32'h104, 1'b0);
        push_exp(32'h108, 1'b0);
        rc0 = req_cnt;
        start(3, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("t3_in_flight", 32'(req_cnt - rc0), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(negedge clk);
        chk("t3_no_req_on_redirect", {31'b0, im_req_valid}, 32'd0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        wait_drain("t3", 60);

        // 2-cycle memory: redirect coincides with a stale response and a pop.
        push_exp(32'h0, 1'b0);
        push_exp(32'h4, 1'b0);
        push_exp(32'h8, 1'b0);
        push_exp(32'hC, 1'b0);
        push_exp(32'h200, 1'b0);
        push_exp(32'h204, 1'b0);
        push_exp(32'h208, 1'b0);
        start(2, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(negedge clk);
        chk("t4_no_req_on_redirect", {31'b0, im_req_valid}, 32'd0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t4_flushed_valid", {31'b0, id_valid}, 32'd0);
        chk("t4_flushed_ir",    id_ir,             NOP);
        wait_drain("t4", 60);

        // Access fault on 0x8 only.
        err_en   = 1'b1;
        err_addr = 32'h8;
        push_exp(32'h0, 1'b0);
        push_exp(32'h4, 1'b0);
        push_exp(32'h8, 1'b1);
        push_exp(32'hC, 1'b0);
        push_exp(32'h10, 1'b0);
        start(1, 1'b1);
        wait_drain("t5", 50);
        err_en = 1'b0;

        // Asynchronous reset with a full queue.
        start(1, 1'b0);
        repeat (8) @(negedge clk);
        chk("t6_full_valid",     {31'b0, id_valid},     32'd1);
        chk("t6_full_ir",        id_ir,                 mem_word(32'h0));
        chk("t6_full_req_valid", {31'b0, im_req_valid}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_req_valid", {31'b0, im_req_valid}, 32'd0);
        chk("t6_rst_id_valid",  {31'b0, id_valid},     32'd0);
        chk("t6_rst_id_ir",     id_ir,                 NOP);
        chk("t6_rst_id_pc",     id_pc,                 32'h0);
        chk("t6_rst_id_fault",  {31'b0, id_fault},     32'd0);
        push_exp(32'h0, 1'b0);
        push_exp(32'h4, 1'b0);
        push_exp(32'h8, 1'b0);
        start(1, 1'b1);
        wait_drain("t6", 50);

        // Misaligned redirect near the top of the address space: PC wraps to 0.
        push_exp(32'hFFFF_FFFC, 1'b0);
        push_exp(32'h0, 1'b0);
        push_exp(32'h4, 1'b0);
        start(1, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFD;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        wait_drain("t7", 50);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by time 100000, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
